// File: rtl/round_controller.sv
// round_controller
//   Match and round sequencer that sits downstream of health_status. It reads
//   both players' health and detects KO, double KO and time-out. It keeps the
//   round wins and drives round_rst, which restores full health between
//   rounds. It also feeds the HUD with the timer, the win counts and the
//   banner state.
//
// Ports
//   clk             in   1  system clock
//   rst             in   1  synchronous reset, active-high
//   frame_tick      in   1  one-cycle pulse per video frame
//   start           in   1  start/confirm button, level
//   player1_health  in   3  P1 health from health_status
//   player2_health  in   3  P2 health from health_status
//   round_rst       out  1  held high to reset health_status and player FSMs
//   fight_active    out  1  high only while fighting; gates player input
//   round_num       out  3  current round, 1-based, saturates at 7
//   timer_sec       out  7  seconds remaining in the round
//   p1_wins         out  2  rounds won by P1
//   p2_wins         out  2  rounds won by P2
//   round_result    out  2  00 none, 01 P1 won, 10 P2 won, 11 draw
//   match_over      out  1  high once a player has taken the match
module round_controller #(
    parameter int MAX_HEALTH     = 3,
    parameter int ROUNDS_TO_WIN  = 2,
    parameter int ROUND_SECS     = 99,
    parameter int FRAMES_PER_SEC = 60,
    parameter int INTRO_FRAMES   = 120,
    parameter int KO_FRAMES      = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [2:0] player1_health,
    input  logic [2:0] player2_health,
    output logic       round_rst,
    output logic       fight_active,
    output logic [2:0] round_num,
    output logic [6:0] timer_sec,
    output logic [1:0] p1_wins,
    output logic [1:0] p2_wins,
    output logic [1:0] round_result,
    output logic       match_over
);

    localparam int FRAME_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int PRE_W     = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    localparam logic [FRAME_W-1:0] INTRO_LOAD  = FRAME_W'(INTRO_FRAMES);
    localparam logic [FRAME_W-1:0] KO_LOAD     = FRAME_W'(KO_FRAMES);
    localparam logic [FRAME_W-1:0] FRAME_ONE   = FRAME_W'(1);
    localparam logic [PRE_W-1:0]   PRE_LAST    = PRE_W'(FRAMES_PER_SEC - 1);
    localparam logic [6:0]         TIMER_START = 7'(ROUND_SECS);
    localparam logic [1:0]         WIN_TARGET  = 2'(ROUNDS_TO_WIN);
    localparam logic [2:0]         HEALTH_MAX  = 3'(MAX_HEALTH);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        INTRO,
        FIGHT,
        KO,
        MATCH_OVER
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] frame_cnt;
    logic [PRE_W-1:0]   prescaler;
    logic               start_prev;

    logic [2:0] h1_eff;
    logic [2:0] h2_eff;
    logic       ko1;
    logic       ko2;
    logic [1:0] outcome;

    // A health value above MAX_HEALTH is what a decrement past zero looks
    // like upstream, so it is treated as a knockout rather than a big number.
    assign h1_eff = (player1_health > HEALTH_MAX) ? 3'd0 : player1_health;
    assign h2_eff = (player2_health > HEALTH_MAX) ? 3'd0 : player2_health;
    assign ko1    = (h1_eff == 3'd0);
    assign ko2    = (h2_eff == 3'd0);

    // Round outcome for the current cycle. KOs come before the time-out, so a
    // KO on the same cycle the clock runs out still counts as a KO.
    always_comb begin
        outcome = RES_NONE;
        if (ko1 && ko2) begin
            outcome = RES_DRAW;
        end else if (ko2) begin
            outcome = RES_P1;
        end else if (ko1) begin
            outcome = RES_P2;
        end else if (timer_sec == 7'd0) begin
            if (h1_eff > h2_eff) begin
                outcome = RES_P1;
            end else if (h2_eff > h1_eff) begin
                outcome = RES_P2;
            end else begin
                outcome = RES_DRAW;
            end
        end
    end

    // Sequencer. Every output is registered here, so round_rst and
    // fight_active change on the same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            round_rst    <= 1'b1;
            fight_active <= 1'b0;
            round_num    <= 3'd1;
            timer_sec    <= TIMER_START;
            p1_wins      <= 2'd0;
            p2_wins      <= 2'd0;
            round_result <= RES_NONE;
            match_over   <= 1'b0;
            frame_cnt    <= '0;
            prescaler    <= '0;
            start_prev   <= 1'b0;
        end else begin
            start_prev <= start;
            case (state)
                IDLE: begin
                    round_rst    <= 1'b1;
                    fight_active <= 1'b0;
                    match_over   <= 1'b0;
                    p1_wins      <= 2'd0;
                    p2_wins      <= 2'd0;
                    round_num    <= 3'd1;
                    if (start) begin
                        state        <= INTRO;
                        frame_cnt    <= INTRO_LOAD;
                        timer_sec    <= TIMER_START;
                        prescaler    <= '0;
                        round_result <= RES_NONE;
                    end
                end

                INTRO: begin
                    if (frame_tick) begin
                        if (frame_cnt <= FRAME_ONE) begin
                            state        <= FIGHT;
                            round_rst    <= 1'b0;
                            fight_active <= 1'b1;
                            frame_cnt    <= '0;
                        end else begin
                            frame_cnt <= frame_cnt - FRAME_ONE;
                        end
                    end
                end

                FIGHT: begin
                    if (frame_tick) begin
                        if (prescaler == PRE_LAST) begin
                            prescaler <= '0;
                            if (timer_sec != 7'd0) begin
                                timer_sec <= timer_sec - 7'd1;
                            end
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end
                    if (outcome != RES_NONE) begin
                        state        <= KO;
                        fight_active <= 1'b0;
                        round_result <= outcome;
                        frame_cnt    <= KO_LOAD;
                        if (outcome == RES_P1 && p1_wins != WIN_TARGET) begin
                            p1_wins <= p1_wins + 2'd1;
                        end
                        if (outcome == RES_P2 && p2_wins != WIN_TARGET) begin
                            p2_wins <= p2_wins + 2'd1;
                        end
                    end
                end

                // round_rst stays low here so the HUD keeps showing the
                // frozen health bars under the KO banner.
                KO: begin
                    if (frame_tick) begin
                        if (frame_cnt <= FRAME_ONE) begin
                            round_rst <= 1'b1;
                            frame_cnt <= '0;
                            if (p1_wins == WIN_TARGET || p2_wins == WIN_TARGET) begin
                                state      <= MATCH_OVER;
                                match_over <= 1'b1;
                            end else begin
                                state        <= INTRO;
                                frame_cnt    <= INTRO_LOAD;
                                timer_sec    <= TIMER_START;
                                prescaler    <= '0;
                                round_result <= RES_NONE;
                                if (round_num != 3'd7) begin
                                    round_num <= round_num + 3'd1;
                                end
                            end
                        end else begin
                            frame_cnt <= frame_cnt - FRAME_ONE;
                        end
                    end
                end

                // Only a fresh press leaves the result screen, so a button
                // still held from the last round cannot skip it.
                MATCH_OVER: begin
                    if (start && !start_prev) begin
                        state        <= IDLE;
                        match_over   <= 1'b0;
                        p1_wins      <= 2'd0;
                        p2_wins      <= 2'd0;
                        round_num    <= 3'd1;
                        timer_sec    <= TIMER_START;
                        round_result <= RES_NONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
`timescale 1ns/1ps

// tb_round_controller
//   Randomized bench for round_controller. The stimulus side plays whole
//   matches and pushes the expected view of each HUD event into scoreboard
//   queues. A monitor process pops those queues and compares them whenever
//   the DUT starts a fight, ends a round or ends a match. The expected
//   values come from a plain model of the match rules.
module tb_round_controller;

    localparam int ROUND_SECS     = 99;
    localparam int FRAMES_PER_SEC = 60;
    localparam int INTRO_FRAMES   = 120;
    localparam int KO_FRAMES      = 180;
    localparam int WIN_TARGET     = 2;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       start;
    logic [2:0] player1_health;
    logic [2:0] player2_health;
    logic       round_rst;
    logic       fight_active;
    logic [2:0] round_num;
    logic [6:0] timer_sec;
    logic [1:0] p1_wins;
    logic [1:0] p2_wins;
    logic [1:0] round_result;
    logic       match_over;

    typedef struct {
        int roundNum;
        int result;
        int p1w;
        int p2w;
        int timer;
    } expT;

    expT fightStartQ[$];
    expT roundEndQ[$];
    expT matchOverQ[$];

    int errCount   = 0;
    int checkCount = 0;

    // Reference match state
    int modelP1Wins;
    int modelP2Wins;
    int modelRound;

    round_controller dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .start          (start),
        .player1_health (player1_health),
        .player2_health (player2_health),
        .round_rst      (round_rst),
        .fight_active   (fight_active),
        .round_num      (round_num),
        .timer_sec      (timer_sec),
        .p1_wins        (p1_wins),
        .p2_wins        (p2_wins),
        .round_result   (round_result),
        .match_over     (match_over)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck DUT still ends the run with a report
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got stuck required finish");
        $display("Result: errors=%0d of %0d checks", errCount + 1, checkCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one clock cycle of inputs, returning 1 ns after the edge
    task automatic applyStimulus(input int h1, input int h2, input bit tick);
        player1_health = 3'(h1);
        player2_health = 3'(h2);
        frame_tick     = tick;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input int h1, input int h2, input int maxGap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(h1, h2, 1'b1);
            repeat ($urandom_range(0, maxGap)) applyStimulus(h1, h2, 1'b0);
        end
    endtask

    // Round outcome from the game rules: 1 P1, 2 P2, 3 draw, 0 none
    function automatic int refOutcome(input int h1, input int h2, input bit timeout);
        int e1 = (h1 > 3) ? 0 : h1;
        int e2 = (h2 > 3) ? 0 : h2;
        if (e1 == 0 && e2 == 0) return 3;
        if (e2 == 0) return 1;
        if (e1 == 0) return 2;
        if (timeout) begin
            if (e1 > e2) return 1;
            if (e2 > e1) return 2;
            return 3;
        end
        return 0;
    endfunction

    task automatic startMatch();
        start = 1'b1;
        applyStimulus(3, 3, 1'b0);
        start = 1'b0;
        modelP1Wins = 0;
        modelP2Wins = 0;
        modelRound  = 1;
        checkOutput("intro round_rst", round_rst, 1);
        checkOutput("intro round_num", round_num, 1);
        checkOutput("intro timer", timer_sec, ROUND_SECS);
    endtask

    task automatic pushFightStart();
        expT e;
        e = '{roundNum: modelRound, result: 0, p1w: modelP1Wins, p2w: modelP2Wins, timer: ROUND_SECS};
        fightStartQ.push_back(e);
    endtask

    // Score a round in the model and queue the expected HUD view
    task automatic scoreRound(input int res, input int timer);
        expT e;
        if (res == 1 && modelP1Wins < WIN_TARGET) modelP1Wins++;
        if (res == 2 && modelP2Wins < WIN_TARGET) modelP2Wins++;
        e = '{roundNum: modelRound, result: res, p1w: modelP1Wins, p2w: modelP2Wins, timer: timer};
        roundEndQ.push_back(e);
        if (modelP1Wins == WIN_TARGET || modelP2Wins == WIN_TARGET) matchOverQ.push_back(e);
    endtask

    // Play one full round: intro, fight ending in (h1,h2), then the KO banner
    task automatic playRound(input bit timeout, input int h1, input int h2);
        int fightTicks;
        int n;
        bit t;
        pushFightStart();
        ticks(INTRO_FRAMES, 3, 3, 2);
        if (timeout) begin
            ticks(ROUND_SECS * FRAMES_PER_SEC, h1, h2, 0);
            checkOutput("timer zero", timer_sec, 0);
            scoreRound(refOutcome(h1, h2, 1'b1), 0);
            applyStimulus(h1, h2, 1'b0);
            checkOutput("timeout latency", fight_active, 0);
        end else begin
            fightTicks = 0;
            n = $urandom_range(5, 150);
            for (int i = 0; i < n; i++) begin
                t = 1'($urandom_range(0, 1));
                applyStimulus($urandom_range(1, 3), $urandom_range(1, 3), t);
                fightTicks += int'(t);
            end
            scoreRound(refOutcome(h1, h2, 1'b0), ROUND_SECS - fightTicks / FRAMES_PER_SEC);
            applyStimulus(h1, h2, 1'b0);
            checkOutput("ko latency", fight_active, 0);
        end
        ticks(KO_FRAMES, h1, h2, 2);
        checkOutput("round_rst after ko", round_rst, 1);
        if (modelP1Wins != WIN_TARGET && modelP2Wins != WIN_TARGET && modelRound < 7)
            modelRound++;
    endtask

    // Hold on the result screen, then press start to return to IDLE
    task automatic endMatch();
        ticks(5, 0, 0, 1);
        checkOutput("match_over hold", match_over, 1);
        start = 1'b1;
        applyStimulus(3, 3, 1'b0);
        start = 1'b0;
        applyStimulus(3, 3, 1'b0);
        checkOutput("idle match_over", match_over, 0);
        checkOutput("idle p1_wins", p1_wins, 0);
        checkOutput("idle p2_wins", p2_wins, 0);
        checkOutput("idle round_num", round_num, 1);
        checkOutput("idle round_rst", round_rst, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " round_rst"}, round_rst, 1);
        checkOutput({tag, " fight_active"}, fight_active, 0);
        checkOutput({tag, " round_num"}, round_num, 1);
        checkOutput({tag, " timer"}, timer_sec, ROUND_SECS);
        checkOutput({tag, " p1_wins"}, p1_wins, 0);
        checkOutput({tag, " p2_wins"}, p2_wins, 0);
        checkOutput({tag, " round_result"}, round_result, 0);
        checkOutput({tag, " match_over"}, match_over, 0);
    endtask

    // Monitor: detects HUD events on the falling edge and checks them
    // against the scoreboard queues.
    initial begin
        bit prevRoundRst;
        bit prevFight;
        bit prevMatchOver;
        expT e;
        prevRoundRst  = 1'b1;
        prevFight     = 1'b0;
        prevMatchOver = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prevRoundRst && round_rst === 1'b0) begin
                    if (fightStartQ.size() == 0) begin
                        checkOutput("unexpected fight start", 1, 0);
                    end else begin
                        e = fightStartQ.pop_front();
                        checkOutput("fight round_num", round_num, e.roundNum);
                        checkOutput("fight timer", timer_sec, e.timer);
                        checkOutput("fight active", fight_active, 1);
                        checkOutput("fight result", round_result, 0);
                    end
                end
                if (prevFight && fight_active === 1'b0 && round_rst === 1'b0) begin
                    if (roundEndQ.size() == 0) begin
                        checkOutput("unexpected round end", 1, 0);
                    end else begin
                        e = roundEndQ.pop_front();
                        checkOutput("end result", round_result, e.result);
                        checkOutput("end p1_wins", p1_wins, e.p1w);
                        checkOutput("end p2_wins", p2_wins, e.p2w);
                        checkOutput("end round_num", round_num, e.roundNum);
                        checkOutput("end timer", timer_sec, e.timer);
                    end
                end
                if (!prevMatchOver && match_over === 1'b1) begin
                    if (matchOverQ.size() == 0) begin
                        checkOutput("unexpected match over", 1, 0);
                    end else begin
                        e = matchOverQ.pop_front();
                        checkOutput("mo p1_wins", p1_wins, e.p1w);
                        checkOutput("mo p2_wins", p2_wins, e.p2w);
                        checkOutput("mo round_rst", round_rst, 1);
                        checkOutput("mo fight_active", fight_active, 0);
                    end
                end
            end
            prevRoundRst  = (round_rst === 1'b1);
            prevFight     = (fight_active === 1'b1);
            prevMatchOver = (match_over === 1'b1);
        end
    end

    // Stimulus: two full matches, then a reset in the middle of a fight
    initial begin
        int c;
        rst            = 1'b1;
        start          = 1'b0;
        frame_tick     = 1'b0;
        player1_health = 3'd3;
        player2_health = 3'd3;
        repeat (3) applyStimulus(3, 3, 1'b0);
        checkResetValues("reset");
        rst = 1'b0;
        applyStimulus(3, 3, 1'b0);
        checkResetValues("idle");

        $display("[TB] match 1: KO, double KO, time-out");
        startMatch();
        playRound(1'b0, 3, 0);
        playRound(1'b0, 0, 0);
        playRound(1'b1, 2, 1);
        endMatch();

        $display("[TB] match 2: equal time-out, wrap, P1 KO, random");
        startMatch();
        playRound(1'b1, 2, 2);
        playRound(1'b0, 3, 7);
        playRound(1'b0, 0, 2);
        for (int r = 0; r < 8 && modelP1Wins < WIN_TARGET && modelP2Wins < WIN_TARGET; r++) begin
            c = $urandom_range(0, 2);
            case (c)
                0:       playRound(1'b0, $urandom_range(1, 3), 0);
                1:       playRound(1'b0, 0, $urandom_range(1, 3));
                default: playRound(1'b0, $urandom_range(1, 3), $urandom_range(4, 7));
            endcase
        end
        endMatch();

        $display("[TB] reset during a fight");
        startMatch();
        playRound(1'b0, 2, 0);
        pushFightStart();
        ticks(INTRO_FRAMES, 3, 3, 1);
        ticks(30, 2, 2, 0);
        checkOutput("pre-reset fight_active", fight_active, 1);
        rst = 1'b1;
        applyStimulus(2, 2, 1'b0);
        rst = 1'b0;
        checkResetValues("mid-fight reset");

        repeat (4) applyStimulus(3, 3, 1'b0);
        checkOutput("fightStartQ drained", fightStartQ.size(), 0);
        checkOutput("roundEndQ drained", roundEndQ.size(), 0);
        checkOutput("matchOverQ drained", matchOverQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
